// File: rtl/chip8_timer_unit.sv
// CHIP-8 delay/sound timers with a 60 Hz prescaler, square-wave beeper,
// and a req/ack register port for the CPU.
//
// state | meaning
// IDLE  | waiting for req; accepts and executes one operation
// RESP  | ack pulse for the accepted operation
// DROP  | waiting for the CPU to release req
module chip8_timer_unit #(
    parameter logic [15:0] TICK_DIV = 16'd5000,
    parameter logic [15:0] TONE_DIV = 16'd64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       tick,
    output logic       delayZero,
    output logic       soundOn,
    output logic       tone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [1:0] OP_RD_DELAY = 2'b00;
    localparam logic [1:0] OP_WR_DELAY = 2'b01;
    localparam logic [1:0] OP_WR_SOUND = 2'b10;
    localparam logic [1:0] OP_RD_SOUND = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] tone_cnt_q, tone_cnt_d;
    logic [7:0]  delay_q, delay_d;
    logic [7:0]  sound_q, sound_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        tone_q, tone_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            tone_cnt_q <= '0;
            delay_q    <= '0;
            sound_q    <= '0;
            rdata_q    <= '0;
            tone_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tone_cnt_q <= tone_cnt_d;
            delay_q    <= delay_d;
            sound_q    <= sound_d;
            rdata_q    <= rdata_d;
            tone_q     <= tone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_RESP;
            S_RESP:  state_d = S_DROP;
            S_DROP:  if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Gating ack with reset keeps a request aborted by reset from being acknowledged.
    always_comb begin
        accept = (state_q == S_IDLE) && req;
        ack    = (state_q == S_RESP) && !reset;
    end

    always_comb begin
        tick    = (presc_q == TICK_DIV - 16'd1);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;

        delay_d = delay_q;
        if (accept && op == OP_WR_DELAY) delay_d = wdata;
        else if (tick && delay_q != 8'd0) delay_d = delay_q - 8'd1;

        sound_d = sound_q;
        if (accept && op == OP_WR_SOUND) sound_d = wdata;
        else if (tick && sound_q != 8'd0) sound_d = sound_q - 8'd1;

        rdata_d = rdata_q;
        if (accept && op == OP_RD_DELAY) rdata_d = delay_q;
        else if (accept && op == OP_RD_SOUND) rdata_d = sound_q;
    end

    // Looking at sound_d silences the beeper in the same cycle soundOn falls.
    always_comb begin
        tone_cnt_d = tone_cnt_q + 16'd1;
        tone_d     = tone_q;
        if (sound_q == 8'd0 || sound_d == 8'd0) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else if (tone_cnt_q == TONE_DIV - 16'd1) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end
    end

    assign rdata     = rdata_q;
    assign tone      = tone_q;
    assign delayZero = (delay_q == 8'd0);
    assign soundOn   = (sound_q != 8'd0);

endmodule
